// File: rtl/alu_div_seq_if.sv
// Bus bundle for the sequential divider: request/result handshake plus the
// operand/result path to the external ALU that performs the subtractions.
interface alu_div_seq_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] alu_out;
  logic [3:0] alu_fun_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       busy;
  logic       done;
  logic       div_err;
  logic [7:0] quotient;
  logic [7:0] remainder;

  modport master (
    output start, dividend, divisor, alu_out,
    input  alu_fun_sel, alu_a, alu_b, busy, done, div_err, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor, alu_out,
    output alu_fun_sel, alu_a, alu_b, busy, done, div_err, quotient, remainder
  );
endinterface

// File: rtl/alu_div_seq.sv
// 8-bit unsigned restoring divider that borrows an external ALU for its
// trial subtractions: one quotient bit per CALC cycle, MSB first.
module alu_div_seq #(
  parameter logic [3:0] SUB_CODE  = 4'b0101,
  parameter logic [3:0] IDLE_CODE = 4'b0000
) (
  input logic         clk,
  input logic         rst,
  alu_div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [7:0] n;
  logic [7:0] d;
  logic [7:0] r;
  logic [7:0] q;
  logic [2:0] k;
  logic [3:0] fun_sel;
  logic       busy;
  logic       done;
  logic       div_err;
  logic [7:0] quotient;
  logic [7:0] remainder;

  logic       t8;
  logic [7:0] t_low;
  logic [7:0] diff;
  logic       ge;
  logic [7:0] r_next;
  logic [7:0] q_next;

  // Shifted partial remainder T = {R, N[k]}; the ALU returns T[7:0] - D, and the
  // 9th bit plus the MSB relationship decide whether T >= D without a wide compare.
  always_comb begin
    t8     = r[7];
    t_low  = {r[6:0], n[k]};
    diff   = bus.alu_out;
    ge     = t8 | (t_low[7] & ~d[7]) | (~(t_low[7] ^ d[7]) & ~diff[7]);
    r_next = ge ? diff : t_low;
    q_next = q;
    q_next[k] = ge;
  end

  assign bus.alu_fun_sel = fun_sel;
  assign bus.alu_a       = (state == CALC) ? t_low : 8'h00;
  assign bus.alu_b       = (state == CALC) ? d     : 8'h00;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_err     = div_err;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= 8'h00;
      d         <= 8'h00;
      r         <= 8'h00;
      q         <= 8'h00;
      k         <= 3'd0;
      fun_sel   <= IDLE_CODE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_err   <= 1'b0;
      quotient  <= 8'h00;
      remainder <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy <= 1'b1;
            if (bus.divisor == 8'h00) begin
              // Divide-by-zero short-circuits straight to DONE; the ALU stays idle.
              state     <= DONE;
              done      <= 1'b1;
              div_err   <= 1'b1;
              quotient  <= 8'hFF;
              remainder <= bus.dividend;
            end else begin
              state   <= CALC;
              n       <= bus.dividend;
              d       <= bus.divisor;
              r       <= 8'h00;
              q       <= 8'h00;
              k       <= 3'd7;
              fun_sel <= SUB_CODE;
            end
          end
        end
        CALC: begin
          r <= r_next;
          q <= q_next;
          k <= k - 3'd1;
          if (k == 3'd0) begin
            state     <= DONE;
            done      <= 1'b1;
            div_err   <= 1'b0;
            quotient  <= q_next;
            remainder <= r_next;
            fun_sel   <= IDLE_CODE;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          fun_sel <= IDLE_CODE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_div_seq.md
ALU_DIV_SEQ -- requirements
Module: alu_div_seq

Interface
REQ-001 Parameter SUB_CODE, default 4'b0101: FunSel code that makes the ALU output A − B.
REQ-002 Parameter IDLE_CODE, default 4'b0000: FunSel code driven when no subtraction is in progress (pass A).
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 Start  input  1  request to begin a division; sampled only in IDLE.
REQ-006 Dividend  input  8  unsigned dividend N.
REQ-007 Divisor  input  8  unsigned divisor D.
REQ-008 AluOut  input  8  combinational result returned by the external ALU for the current AluFunSel/AluA/AluB.
REQ-009 AluFunSel  output  4  FunSel driven to the external ALU.
REQ-010 AluA  output  8  A operand to the ALU.
REQ-011 AluB  output  8  B operand to the ALU.
REQ-012 Busy  output  1  high in CALC and DONE.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 DivErr  output  1  divide-by-zero flag for the last completed operation.
REQ-015 Quotient  output  8  registered quotient of the last completed operation.
REQ-016 Remainder  output  8  registered remainder of the last completed operation.

Function
REQ-017 The FSM SHALL have states IDLE, CALC and DONE.
REQ-018 In IDLE with Start=1 and Divisor≠0: latch N and D, clear partial remainder R and partial quotient Q, set bit index k=7, go to CALC.
REQ-019 In IDLE with Start=1 and Divisor=0: go directly to DONE with DivErr←1, Quotient←8'hFF, Remainder←Dividend; the ALU is not used.
REQ-020 Start SHALL be ignored in CALC and DONE; Dividend/Divisor changes after acceptance SHALL NOT affect the running operation.
REQ-021 Each CALC cycle: form T = {R, N[k]} (9 bits, t8 = R[7]); drive AluFunSel=SUB_CODE, AluA=T[7:0], AluB=D; sample AluOut in the same cycle as diff.
REQ-022 ge = t8 | (T[7] & ~D[7]) | (~(T[7]^D[7]) & ~diff[7]) (unsigned T ≥ D).
REQ-023 At the CALC edge: if ge, R←diff and Q[k]←1; else R←T[7:0] and Q[k]←0; then k←k−1.
REQ-024 CALC SHALL last exactly 8 cycles (k=7..0); the edge processing k=0 SHALL load Quotient←Q (final), Remainder←R (final), DivErr←0, and go to DONE.
REQ-025 DONE SHALL last one cycle with Done=1, then return unconditionally to IDLE.
REQ-026 Outside CALC: AluFunSel=IDLE_CODE, AluA=8'h00, AluB=8'h00.
REQ-027 Latency: Done high in the cycle after the 9th rising edge counted from the edge that samples Start (inclusive); for divide-by-zero, in the cycle after that edge.
REQ-028 Quotient, Remainder and DivErr SHALL hold their values from DONE until the next DONE.
REQ-029 Back-to-back operations: Start held high SHALL be accepted again in the first IDLE cycle after DONE.

Reset
REQ-030 RST=1 SHALL immediately force IDLE, Busy=0, Done=0, DivErr=0, Quotient=0, Remainder=0, AluFunSel=IDLE_CODE, AluA=AluB=0, and clear R, Q, k, N, D, regardless of state.
REQ-031 Assertion mid-CALC SHALL abort without a Done pulse; after release the block SHALL wait in IDLE for a new Start.

Verification
REQ-032 100/7, with an ideal ALU model attached -> Done after 9 edges, Quotient=14, Remainder=2, DivErr=0; AluFunSel=0101 for exactly 8 cycles.
REQ-033 200/201 and 255/128 -> Quotient=0 Remainder=200; Quotient=1 Remainder=127 (covers the T[7]/D[7] sign cases).
REQ-034 255/1 and 0/9 -> Quotient=255 Remainder=0; Quotient=0 Remainder=0.
REQ-035 5/0 -> Done in the cycle after the Start edge, DivErr=1, Quotient=8'hFF, Remainder=8'h05; AluFunSel stays 0000.
REQ-036 Start 100/7, then Start pulse 50/5 during CALC -> the second request is ignored and the result is 14 r 2; RST asserted at the 4th CALC cycle -> all outputs are 0 immediately and no Done pulse occurs.
